// File: rtl/spmv_pkg.sv
// rtl/spmv_pkg.sv - shared types and arithmetic helpers for the SpMV product pipe
package spmv_pkg;

    typedef struct packed {
        logic mask;
        logic ovf;
    } lane_flags_t;

    // Positive infinity: all-ones exponent, zero mantissa, sign clear.
    function automatic logic [63:0] inf_enc(input int ew, input int fw);
        return ((64'd1 << ew) - 64'd1) << fw;
    endfunction

    // Canonical quiet NaN: infinity pattern plus the mantissa MSB.
    function automatic logic [63:0] qnan_enc(input int ew, input int fw);
        return inf_enc(ew, fw) | (64'd1 << (fw - 1));
    endfunction

    // Signed fixed-point multiply: round half up at the binary point, then
    // saturate to a dw-bit signed range. Returns {ovf, result}.
    function automatic logic [64:0] fx_mul_sat(input logic signed [63:0] a,
                                               input logic signed [63:0] b,
                                               input int dw, input int frac);
        logic signed [127:0] p;
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        logic        [64:0]  res;
        p = $signed(128'(a)) * $signed(128'(b));
        if (frac > 0) begin
            p = p + (128'sd1 <<< (frac - 1));
        end
        p  = p >>> frac;
        hi = (128'sd1 <<< (dw - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (dw - 1));
        if (p > hi) begin
            res = {1'b1, hi[63:0]};
        end else if (p < lo) begin
            res = {1'b1, lo[63:0]};
        end else begin
            res = {1'b0, p[63:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/product_pipe_if.sv
// rtl/product_pipe_if.sv - beat-level bus of the product pipe
interface product_pipe_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int PARALLELISM = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [PARALLELISM-1:0] in_mask;
    logic                   in_last;
    logic [DATA_WIDTH-1:0]  a   [PARALLELISM-1:0];
    logic [DATA_WIDTH-1:0]  b   [PARALLELISM-1:0];
    logic [DATA_WIDTH-1:0]  out [PARALLELISM-1:0];
    logic [PARALLELISM-1:0] out_mask;
    logic                   out_last;
    logic [PARALLELISM-1:0] ovf;
    logic                   valid;
    logic                   ready;

    modport master (
        output in_valid, in_mask, in_last, a, b, ready,
        input  in_ready, out, out_mask, out_last, ovf, valid
    );

    modport slave (
        input  in_valid, in_mask, in_last, a, b, ready,
        output in_ready, out, out_mask, out_last, ovf, valid
    );
endinterface

// File: rtl/product_lane.sv
// rtl/product_lane.sv - combinational single-lane multiply, fixed or float
module product_lane
    import spmv_pkg::*;
#(
    parameter int FLOAT      = 1,
    parameter int DATA_WIDTH = 32,
    parameter int E_WIDTH    = 8,
    parameter int FRAC_WIDTH = 23
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] y_o,
    output logic                  ovf_o
);

    generate
        if (FLOAT == 0) begin : g_fx
            logic [64:0] r;
            logic        unused_fx;

            // Full-width product, rounded and saturated by the shared helper.
            always_comb begin
                r = fx_mul_sat(64'($signed(a_i)), 64'($signed(b_i)), DATA_WIDTH, FRAC_WIDTH);
            end

            assign y_o       = r[DATA_WIDTH-1:0];
            assign ovf_o     = r[64];
            // Bits above the element width are sign copies; folding them marks them consumed.
            assign unused_fx = ^r;
        end else begin : g_fp
            localparam int E  = E_WIDTH;
            localparam int F  = FRAC_WIDTH;
            localparam int PW = 2 * F + 2;
            localparam logic [DATA_WIDTH-1:0] QNAN  = DATA_WIDTH'(qnan_enc(E, F));
            localparam logic [DATA_WIDTH-1:0] INF   = DATA_WIDTH'(inf_enc(E, F));
            localparam logic signed [E+1:0]   BIAS  = (E + 2)'((1 << (E - 1)) - 1);
            localparam logic signed [E+1:0]   EMAX  = (E + 2)'((1 << E) - 1);
            localparam logic signed [E+1:0]   EZERO = '0;

            logic              sa, sb, s;
            logic [E-1:0]      ea, eb;
            logic [F-1:0]      ma, mb;
            logic              za, zb, ia, ib, na, nb;
            logic [PW-1:0]     prod, norm;
            logic              guard, sticky, rup;
            logic [F:0]        mant_r;
            logic signed [E+1:0] ea_x, eb_x, nrm_x, rnd_x, exp_s, exp_r;
            logic              unused_fp;

            assign {sa, ea, ma} = a_i;
            assign {sb, eb, mb} = b_i;
            assign unused_fp    = norm[PW-1];

            // Classify operands, multiply significands, normalise, round to nearest even,
            // then resolve specials, overflow and flush-to-zero in priority order.
            always_comb begin
                s      = sa ^ sb;
                za     = (ea == '0);
                zb     = (eb == '0);
                ia     = (&ea) && (ma == '0);
                ib     = (&eb) && (mb == '0);
                na     = (&ea) && (ma != '0);
                nb     = (&eb) && (mb != '0);
                prod   = PW'({1'b1, ma}) * PW'({1'b1, mb});
                norm   = prod[PW-1] ? prod : (prod << 1);
                guard  = norm[F];
                sticky = |norm[F-1:0];
                rup    = guard & (sticky | norm[F+1]);
                mant_r = {1'b0, norm[2*F:F+1]} + {{F{1'b0}}, rup};
                ea_x   = {2'b00, ea};
                eb_x   = {2'b00, eb};
                nrm_x  = {{(E + 1){1'b0}}, prod[PW-1]};
                rnd_x  = {{(E + 1){1'b0}}, mant_r[F]};
                exp_s  = ea_x + eb_x - BIAS + nrm_x;
                exp_r  = exp_s + rnd_x;

                y_o   = '0;
                ovf_o = 1'b0;
                if (na || nb || (ia && zb) || (za && ib)) begin
                    y_o = QNAN;
                end else if (ia || ib) begin
                    y_o = {s, INF[DATA_WIDTH-2:0]};
                end else if (za || zb) begin
                    y_o = {s, {(DATA_WIDTH - 1){1'b0}}};
                end else if (exp_r >= EMAX) begin
                    y_o   = {s, INF[DATA_WIDTH-2:0]};
                    ovf_o = 1'b1;
                end else if (exp_r <= EZERO) begin
                    y_o = {s, {(DATA_WIDTH - 1){1'b0}}};
                end else begin
                    y_o = {s, exp_r[E-1:0], mant_r[F-1:0]};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/product_pipe.sv
// rtl/product_pipe.sv - elastic pipelined element-wise multiplier
module product_pipe
    import spmv_pkg::*;
#(
    parameter int FLOAT       = 1,
    parameter int DATA_WIDTH  = 32,
    parameter int E_WIDTH     = 8,
    parameter int FRAC_WIDTH  = 23,
    parameter int PARALLELISM = 4,
    parameter int LATENCY     = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    product_pipe_if.slave bus
);

    localparam int DW = DATA_WIDTH;
    localparam int P  = PARALLELISM;
    localparam int L  = LATENCY;

    logic [DW-1:0]           lane_y   [P];
    logic                    lane_ovf [P];
    logic [P*DW-1:0]         lane_data;
    lane_flags_t [P-1:0]     lane_flags;

    logic [L-1:0]            valid_q, valid_d;
    logic [L-1:0]            ld, adv;
    logic [L-1:0]            last_q;
    logic [P*DW-1:0]         data_q    [L];
    lane_flags_t [P-1:0]     flags_q   [L];

    logic [L-1:0]            src_v;
    logic [L-1:0]            src_last;
    logic [P*DW-1:0]         src_data  [L];
    lane_flags_t [P-1:0]     src_flags [L];

    genvar i, k;
    generate
        for (i = 0; i < P; i++) begin : g_lane
            product_lane #(
                .FLOAT      (FLOAT),
                .DATA_WIDTH (DW),
                .E_WIDTH    (E_WIDTH),
                .FRAC_WIDTH (FRAC_WIDTH)
            ) u_lane (
                .a_i   (bus.a[i]),
                .b_i   (bus.b[i]),
                .y_o   (lane_y[i]),
                .ovf_o (lane_ovf[i])
            );
            // Disabled lanes are zeroed before the product register.
            assign lane_data[i*DW +: DW] = bus.in_mask[i] ? lane_y[i] : '0;
            assign lane_flags[i].mask    = bus.in_mask[i];
            assign lane_flags[i].ovf     = bus.in_mask[i] & lane_ovf[i];

            assign bus.out[i]      = data_q[L-1][i*DW +: DW];
            assign bus.out_mask[i] = flags_q[L-1][i].mask;
            assign bus.ovf[i]      = flags_q[L-1][i].ovf;
        end

        for (k = 0; k < L; k++) begin : g_src
            if (k == 0) begin : g_head
                assign src_v[k]     = bus.in_valid;
                assign src_last[k]  = bus.in_last;
                assign src_data[k]  = lane_data;
                assign src_flags[k] = lane_flags;
            end else begin : g_body
                assign src_v[k]     = valid_q[k-1];
                assign src_last[k]  = last_q[k-1];
                assign src_data[k]  = data_q[k-1];
                assign src_flags[k] = flags_q[k-1];
            end
        end
    endgenerate

    // Walk from the output back to the input so each stage sees whether its successor loads.
    always_comb begin
        logic down;
        down    = bus.ready;
        ld      = '0;
        adv     = '0;
        valid_d = valid_q;
        for (int s = L - 1; s >= 0; s--) begin
            adv[s] = valid_q[s] & down;
            ld[s]  = src_v[s] & (~valid_q[s] | adv[s]);
            if (ld[s]) begin
                valid_d[s] = 1'b1;
            end else if (adv[s]) begin
                valid_d[s] = 1'b0;
            end
            down = ld[s];
        end
    end

    assign bus.in_ready = ~valid_q[0] | adv[0];
    assign bus.valid    = valid_q[L-1];
    assign bus.out_last = last_q[L-1];

    // Stage occupancy flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Stage payloads move only on load, so a stalled stage holds its beat unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
            for (int s = 0; s < L; s++) begin
                data_q[s]  <= '0;
                flags_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < L; s++) begin
                if (ld[s]) begin
                    data_q[s]  <= src_data[s];
                    flags_q[s] <= src_flags[s];
                    last_q[s]  <= src_last[s];
                end
            end
        end
    end

endmodule
